poly_scheduler: RTL

POLY_SCHEDULER -- requirements
Module: poly_scheduler

---
 rtl/poly_scheduler.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/poly_scheduler.sv
// poly_scheduler: decodes a byte-wide command stream into double-buffered
//   polygon slot state (shadow) and commits it to the rasterizer-facing
//   outputs only on frame_start.
// Latency: shadow updates land the cycle after the last byte of a command is
//   accepted; outputs change only on the cycle after a frame_start pulse.
// Backpressure: cmd_ready is high in IDLE and PAYLOAD and low for the single
//   STORE cycle that follows the seventh payload byte of WRITE_POLY.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   cmd_valid/cmd_data    - command byte stream, accepted when cmd_ready high
//   cmd_ready             - byte acceptance
//   frame_start           - one-cycle pulse, commits shadow to outputs
//   v{0,1,2}_x / _y       - packed {slot1, slot0} vertex coordinates
//   poly_color            - packed {slot1, slot0} rrggbb colors
//   cmp_en                - per-slot rasterization enable
//   background_color      - active background color
//   busy                  - high while a WRITE_POLY packet is in flight
//
// Optional feature: define POLY_SCHED_TIMEOUT_EN to abort a stalled packet
// after TIMEOUT_CYCLES consecutive cycles without an accepted payload byte.

module poly_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        frame_start,
  output logic [13:0] v0_x,
  output logic [13:0] v1_x,
  output logic [13:0] v2_x,
  output logic [11:0] v0_y,
  output logic [11:0] v1_y,
  output logic [11:0] v2_y,
  output logic [11:0] poly_color,
  output logic [1:0]  cmp_en,
  output logic [5:0]  background_color,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_STORE   = 2'd2
  } state_t;

  localparam logic [1:0] OP_WRITE_POLY = 2'b01;
  localparam logic [1:0] OP_SET_BG     = 2'b10;
  localparam logic [1:0] OP_DISABLE    = 2'b11;

  // FSM state and registered handshake/status outputs
  state_t     state_q;
  logic [2:0] cnt_q;
  logic       slot_q;
  logic       rdy_q;
  logic       busy_q;

  // Single-byte commands are applied to the shadow one cycle after acceptance
  logic       bg_pend_q;
  logic [5:0] bg_val_q;
  logic       dis_pend_q;
  logic       dis_slot_q;

  // Staging register for the WRITE_POLY payload
  logic [6:0] stg_v0x_q, stg_v1x_q, stg_v2x_q;
  logic [5:0] stg_v0y_q, stg_v1y_q, stg_v2y_q;
  logic [5:0] stg_col_q;

  // Shadow slot state, indexed by slot number
  logic [6:0] sh_v0x_q [2];
  logic [6:0] sh_v1x_q [2];
  logic [6:0] sh_v2x_q [2];
  logic [5:0] sh_v0y_q [2];
  logic [5:0] sh_v1y_q [2];
  logic [5:0] sh_v2y_q [2];
  logic [5:0] sh_col_q [2];
  logic [1:0] sh_en_q;
  logic [5:0] sh_bg_q;

  // Active (committed) state driving the outputs
  logic [13:0] act_v0x_q, act_v1x_q, act_v2x_q;
  logic [11:0] act_v0y_q, act_v1y_q, act_v2y_q;
  logic [11:0] act_col_q;
  logic [1:0]  act_en_q;
  logic [5:0]  act_bg_q;

  logic accept;
  logic to_abort;

  assign accept = cmd_valid & rdy_q;

`ifdef POLY_SCHED_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1: the abort fires on the
  // idle cycle that would make it TIMEOUT_CYCLES.
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;

  assign to_abort = (state_q == ST_PAYLOAD) && !accept &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q != ST_PAYLOAD) || accept || to_abort) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // No timeout: PAYLOAD waits indefinitely for the remaining bytes.
  logic unused_timeout_param;
  assign to_abort             = 1'b0;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

  // Command FSM: header decode, payload collection into staging, STORE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      slot_q     <= 1'b0;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      bg_pend_q  <= 1'b0;
      bg_val_q   <= 6'd0;
      dis_pend_q <= 1'b0;
      dis_slot_q <= 1'b0;
      stg_v0x_q  <= 7'd0;
      stg_v1x_q  <= 7'd0;
      stg_v2x_q  <= 7'd0;
      stg_v0y_q  <= 6'd0;
      stg_v1y_q  <= 6'd0;
      stg_v2y_q  <= 6'd0;
      stg_col_q  <= 6'd0;
    end else begin
      bg_pend_q  <= 1'b0;
      dis_pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_data[7:6])
              OP_WRITE_POLY: begin
                state_q <= ST_PAYLOAD;
                cnt_q   <= 3'd0;
                slot_q  <= cmd_data[0];
                busy_q  <= 1'b1;
              end
              OP_SET_BG: begin
                bg_pend_q <= 1'b1;
                bg_val_q  <= cmd_data[5:0];
              end
              OP_DISABLE: begin
                dis_pend_q <= 1'b1;
                dis_slot_q <= cmd_data[0];
              end
              default: ; // NOP
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            case (cnt_q)
              3'd0:    stg_v0x_q <= cmd_data[6:0];
              3'd1:    stg_v0y_q <= cmd_data[5:0];
              3'd2:    stg_v1x_q <= cmd_data[6:0];
              3'd3:    stg_v1y_q <= cmd_data[5:0];
              3'd4:    stg_v2x_q <= cmd_data[6:0];
              3'd5:    stg_v2y_q <= cmd_data[5:0];
              default: stg_col_q <= cmd_data[5:0];
            endcase
            if (cnt_q == 3'd6) begin
              state_q <= ST_STORE;
              cnt_q   <= 3'd0;
              rdy_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end else if (to_abort) begin
            // Stalled packet: drop the partial payload, shadow untouched.
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b0;
            stg_v0x_q <= 7'd0;
            stg_v1x_q <= 7'd0;
            stg_v2x_q <= 7'd0;
            stg_v0y_q <= 6'd0;
            stg_v1y_q <= 6'd0;
            stg_v2y_q <= 6'd0;
            stg_col_q <= 6'd0;
          end
        end
        ST_STORE: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow state. STORE and DISABLE can never fall in the same cycle since
  // DISABLE is only decoded in IDLE and its update lands one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        sh_v0x_q[s] <= 7'd0;
        sh_v1x_q[s] <= 7'd0;
        sh_v2x_q[s] <= 7'd0;
        sh_v0y_q[s] <= 6'd0;
        sh_v1y_q[s] <= 6'd0;
        sh_v2y_q[s] <= 6'd0;
        sh_col_q[s] <= 6'd0;
      end
      sh_en_q <= 2'b00;
      sh_bg_q <= 6'd0;
    end else begin
      if (state_q == ST_STORE) begin
        sh_v0x_q[slot_q] <= stg_v0x_q;
        sh_v1x_q[slot_q] <= stg_v1x_q;
        sh_v2x_q[slot_q] <= stg_v2x_q;
        sh_v0y_q[slot_q] <= stg_v0y_q;
        sh_v1y_q[slot_q] <= stg_v1y_q;
        sh_v2y_q[slot_q] <= stg_v2y_q;
        sh_col_q[slot_q] <= stg_col_q;
        sh_en_q[slot_q]  <= 1'b1;
      end
      if (bg_pend_q) begin
        sh_bg_q <= bg_val_q;
      end
      if (dis_pend_q) begin
        sh_en_q[dis_slot_q] <= 1'b0;
      end
    end
  end

  // Commit on frame_start. Reading the shadow registers here gives their
  // pre-update value when a shadow write lands on the same edge, so a
  // coincident update is deferred to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_v0x_q <= 14'd0;
      act_v1x_q <= 14'd0;
      act_v2x_q <= 14'd0;
      act_v0y_q <= 12'd0;
      act_v1y_q <= 12'd0;
      act_v2y_q <= 12'd0;
      act_col_q <= 12'd0;
      act_en_q  <= 2'b00;
      act_bg_q  <= 6'd0;
    end else if (frame_start) begin
      act_v0x_q <= {sh_v0x_q[1], sh_v0x_q[0]};
      act_v1x_q <= {sh_v1x_q[1], sh_v1x_q[0]};
      act_v2x_q <= {sh_v2x_q[1], sh_v2x_q[0]};
      act_v0y_q <= {sh_v0y_q[1], sh_v0y_q[0]};
      act_v1y_q <= {sh_v1y_q[1], sh_v1y_q[0]};
      act_v2y_q <= {sh_v2y_q[1], sh_v2y_q[0]};
      act_col_q <= {sh_col_q[1], sh_col_q[0]};
      act_en_q  <= sh_en_q;
      act_bg_q  <= sh_bg_q;
    end
  end

  assign cmd_ready        = rdy_q;
  assign busy             = busy_q;
  assign v0_x             = act_v0x_q;
  assign v1_x             = act_v1x_q;
  assign v2_x             = act_v2x_q;
  assign v0_y             = act_v0y_q;
  assign v1_y             = act_v1y_q;
  assign v2_y             = act_v2y_q;
  assign poly_color       = act_col_q;
  assign cmp_en           = act_en_q;
  assign background_color = act_bg_q;

endmodule
